// File: rtl/btn_pkg.sv
// Shared definitions for the pushbutton debounce/toggle path: FSM state
// encoding and the default debounce window (10 ms at 50 MHz).
package btn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } btn_state_e;

  localparam int DEBOUNCE_CYCLES_DEF = 500000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input; shared by the
// button and switch inputs of the lab designs.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/btn_toggle_pulse.sv
// Debounces a raw pushbutton and emits one registered single-cycle pulse per
// accepted press, intended to drive the t input of a downstream T flip-flop.
module btn_toggle_pulse
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic t_pulse,
  output logic btn_level
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             s;
  btn_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc_d;
  logic             pulse_q;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (btn_in),
    .q_o (s)
  );

  assign cnt_inc_d = cnt_q + CNT_ONE;

  // The counter only runs while waiting and stops at CNT_MAX, so it never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (s) begin
            state_q <= ST_PRESS_WAIT;
            cnt_q   <= CNT_ONE;
          end
        end
        ST_PRESS_WAIT: begin
          if (!s) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_MAX) begin
            state_q <= ST_PRESSED;
            cnt_q   <= '0;
            pulse_q <= 1'b1;
          end else begin
            cnt_q   <= cnt_inc_d;
          end
        end
        ST_PRESSED: begin
          if (!s) begin
            state_q <= ST_RELEASE_WAIT;
            cnt_q   <= CNT_ONE;
          end
        end
        ST_RELEASE_WAIT: begin
          if (s) begin
            state_q <= ST_PRESSED;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_MAX) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q   <= cnt_inc_d;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Level is a pure decode of the state register, so it cannot glitch.
  assign btn_level = (state_q == ST_PRESSED) || (state_q == ST_RELEASE_WAIT);
  assign t_pulse   = pulse_q;

endmodule
